// File: rtl/demux_router_if.sv
// Bundled handshake/bus signals for the 10-port demux router.
// master = upstream producer plus port consumers, slave = the router itself.
interface demux_router_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 4,
  parameter int NUM_PORTS  = 10
);
  logic [SEL_WIDTH-1:0]  sel;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  ready_out;
  logic [DATA_WIDTH-1:0] port0_out;
  logic [DATA_WIDTH-1:0] port1_out;
  logic [DATA_WIDTH-1:0] port2_out;
  logic [DATA_WIDTH-1:0] port3_out;
  logic [DATA_WIDTH-1:0] port4_out;
  logic [DATA_WIDTH-1:0] port5_out;
  logic [DATA_WIDTH-1:0] port6_out;
  logic [DATA_WIDTH-1:0] port7_out;
  logic [DATA_WIDTH-1:0] port8_out;
  logic [DATA_WIDTH-1:0] port9_out;
  logic [NUM_PORTS-1:0]  port_valid;
  logic [NUM_PORTS-1:0]  port_ready;
  logic [7:0]            drop_count;
  logic                  sel_err;

  modport master (
    output sel, data_in, valid_in, port_ready,
    input  ready_out, port_valid, drop_count, sel_err,
    input  port0_out, port1_out, port2_out, port3_out, port4_out,
    input  port5_out, port6_out, port7_out, port8_out, port9_out
  );

  modport slave (
    input  sel, data_in, valid_in, port_ready,
    output ready_out, port_valid, drop_count, sel_err,
    output port0_out, port1_out, port2_out, port3_out, port4_out,
    output port5_out, port6_out, port7_out, port8_out, port9_out
  );
endinterface

// File: rtl/demux_router.sv
// Routes one valid/ready stream to 10 output ports, each with a one-entry
// holding register; illegal selects are consumed, dropped and counted.
module demux_router #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 4,
  parameter int NUM_PORTS  = 10
) (
  input logic          clk,
  input logic          rst,
  demux_router_if.slave bus
);
  localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(NUM_PORTS - 1);

  logic [DATA_WIDTH-1:0] hold [NUM_PORTS];
  logic [NUM_PORTS-1:0]  valid_q;
  logic [NUM_PORTS-1:0]  fill;
  logic [NUM_PORTS-1:0]  drain;
  logic [7:0]            drop_q;
  logic                  err_q;
  logic                  sel_legal;
  logic                  ready;
  logic                  accept;
  logic                  drop;

  assign sel_legal = (bus.sel <= LAST_SEL);

  // A full port can still take a new beat when its consumer drains this cycle.
  always_comb begin
    ready = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (bus.sel == SEL_WIDTH'(i)) ready = !valid_q[i] || bus.port_ready[i];
    end
  end

  assign accept = bus.valid_in && ready;
  assign drop   = bus.valid_in && !sel_legal;
  assign drain  = valid_q & bus.port_ready;

  always_comb begin
    fill = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      fill[i] = accept && (bus.sel == SEL_WIDTH'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      drop_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (fill[i]) begin
          hold[i]    <= bus.data_in;
          valid_q[i] <= 1'b1;
        end else if (drain[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
      if (drop) begin
        err_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
    end
  end

  assign bus.ready_out  = ready;
  assign bus.port_valid = valid_q;
  assign bus.drop_count = drop_q;
  assign bus.sel_err    = err_q;
  assign bus.port0_out  = hold[0];
  assign bus.port1_out  = hold[1];
  assign bus.port2_out  = hold[2];
  assign bus.port3_out  = hold[3];
  assign bus.port4_out  = hold[4];
  assign bus.port5_out  = hold[5];
  assign bus.port6_out  = hold[6];
  assign bus.port7_out  = hold[7];
  assign bus.port8_out  = hold[8];
  assign bus.port9_out  = hold[9];
endmodule

// File: tb/tb_demux_router.sv
// Bench for demux_router: vector table for routing/stall behaviour, per-port
// scoreboard checking every drained beat, plus reset and illegal-select sequences.
`timescale 1ns/1ps
module tb_demux_router;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  demux_router_if #(.DATA_WIDTH(8), .SEL_WIDTH(4), .NUM_PORTS(10)) bus ();

  demux_router #(.DATA_WIDTH(8), .SEL_WIDTH(4), .NUM_PORTS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] pout [10];
  assign pout[0] = bus.port0_out;
  assign pout[1] = bus.port1_out;
  assign pout[2] = bus.port2_out;
  assign pout[3] = bus.port3_out;
  assign pout[4] = bus.port4_out;
  assign pout[5] = bus.port5_out;
  assign pout[6] = bus.port6_out;
  assign pout[7] = bus.port7_out;
  assign pout[8] = bus.port8_out;
  assign pout[9] = bus.port9_out;

  logic [7:0] exp_q [10][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: accepted legal beats are queued per port, drained beats compared.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 10; i++) begin
        if (bus.port_valid[i] && bus.port_ready[i]) begin
          if (exp_q[i].size() == 0) check($sformatf("drain_unexpected_p%0d", i), 32'(pout[i]), 32'hFFFF_FFFF);
          else check($sformatf("drain_data_p%0d", i), 32'(pout[i]), 32'(exp_q[i].pop_front()));
        end
      end
      if (bus.valid_in && bus.ready_out && bus.sel < 4'd10) exp_q[bus.sel].push_back(bus.data_in);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] sel;
    logic [7:0] data;
    logic       valid;
    logic [9:0] pready;
    logic       exp_ready;
    logic [9:0] pv_mask;
    logic [9:0] exp_pv;
    int         chk_port;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [18];

  task automatic drive(input logic [3:0] s, input logic [7:0] d, input logic v, input logic [9:0] pr);
    bus.sel = s; bus.data_in = d; bus.valid_in = v; bus.port_ready = pr;
  endtask

  initial begin
    vecs[0]  = '{4'd3, 8'hA5, 1'b1, 10'h000, 1'b1, 10'h3FF, 10'h000, -1, 8'h00};
    vecs[1]  = '{4'd3, 8'h00, 1'b0, 10'h000, 1'b0, 10'h3FF, 10'h008,  3, 8'hA5};
    vecs[2]  = '{4'd7, 8'h01, 1'b1, 10'h080, 1'b1, 10'h3FF, 10'h008, -1, 8'h00};
    vecs[3]  = '{4'd7, 8'h02, 1'b1, 10'h080, 1'b1, 10'h3FF, 10'h088,  7, 8'h01};
    vecs[4]  = '{4'd7, 8'h03, 1'b1, 10'h080, 1'b1, 10'h3FF, 10'h088,  7, 8'h02};
    vecs[5]  = '{4'd7, 8'h00, 1'b0, 10'h080, 1'b1, 10'h080, 10'h080,  7, 8'h03};
    vecs[6]  = '{4'd2, 8'hC3, 1'b1, 10'h000, 1'b1, 10'h3FF, 10'h008,  3, 8'hA5};
    vecs[7]  = '{4'd5, 8'h3C, 1'b1, 10'h000, 1'b1, 10'h3FF, 10'h00C,  2, 8'hC3};
    vecs[8]  = '{4'd2, 8'h99, 1'b1, 10'h000, 1'b0, 10'h3FF, 10'h02C,  5, 8'h3C};
    vecs[9]  = '{4'd2, 8'h99, 1'b1, 10'h000, 1'b0, 10'h3FF, 10'h02C,  2, 8'hC3};
    vecs[10] = '{4'd2, 8'h99, 1'b1, 10'h004, 1'b1, 10'h3FF, 10'h02C,  2, 8'hC3};
    vecs[11] = '{4'd2, 8'h00, 1'b0, 10'h024, 1'b1, 10'h3FF, 10'h02C,  2, 8'h99};
    vecs[12] = '{4'd0, 8'h00, 1'b0, 10'h000, 1'b1, 10'h3FF, 10'h008,  3, 8'hA5};
    vecs[13] = '{4'd3, 8'h00, 1'b0, 10'h008, 1'b1, 10'h3FF, 10'h008, -1, 8'h00};
    vecs[14] = '{4'd9, 8'hE7, 1'b1, 10'h000, 1'b1, 10'h3FF, 10'h000, -1, 8'h00};
    vecs[15] = '{4'd0, 8'h10, 1'b1, 10'h000, 1'b1, 10'h3FF, 10'h200,  9, 8'hE7};
    vecs[16] = '{4'd4, 8'h44, 1'b1, 10'h000, 1'b1, 10'h3FF, 10'h201,  0, 8'h10};
    vecs[17] = '{4'd4, 8'h00, 1'b0, 10'h000, 1'b0, 10'h3FF, 10'h211,  4, 8'h44};

    // Reset with random inputs
    drive(4'(($urandom)), 8'($urandom), 1'b1, 10'($urandom));
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      drive(4'($urandom), 8'($urandom), 1'($urandom), 10'($urandom));
      @(negedge clk);
      check("rst_port_valid", 32'(bus.port_valid), 32'h0);
    end
    for (int i = 0; i < 10; i++) check($sformatf("rst_port%0d_out", i), 32'(pout[i]), 32'h0);
    check("rst_drop_count", 32'(bus.drop_count), 32'h0);
    check("rst_sel_err", 32'(bus.sel_err), 32'h0);

    @(posedge clk); #1;
    rst = 1'b0;
    drive(4'd0, 8'h00, 1'b0, 10'h000);
    for (int s = 0; s < 10; s++) begin
      @(posedge clk); #1;
      bus.sel = 4'(s);
      @(negedge clk);
      check($sformatf("idle_ready_sel%0d", s), 32'(bus.ready_out), 32'h1);
    end

    for (int k = 0; k < 18; k++) begin
      @(posedge clk); #1;
      drive(vecs[k].sel, vecs[k].data, vecs[k].valid, vecs[k].pready);
      @(negedge clk);
      check($sformatf("vec%0d_ready", k), 32'(bus.ready_out), 32'(vecs[k].exp_ready));
      check($sformatf("vec%0d_port_valid", k), 32'(bus.port_valid & vecs[k].pv_mask), 32'(vecs[k].exp_pv));
      if (vecs[k].chk_port >= 0)
        check($sformatf("vec%0d_port%0d_out", k, vecs[k].chk_port), 32'(pout[vecs[k].chk_port]), 32'(vecs[k].exp_data));
    end

    // Asynchronous reset between edges with ports 0, 4, 9 full
    #2 rst = 1'b1;
    #1 check("async_rst_port_valid", 32'(bus.port_valid), 32'h0);
    check("async_rst_port4_out", 32'(bus.port4_out), 32'h0);
    for (int i = 0; i < 10; i++) exp_q[i].delete();
    @(posedge clk); #1;
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    drive(4'd4, 8'h77, 1'b1, 10'h000);
    @(negedge clk);
    check("post_rst_ready", 32'(bus.ready_out), 32'h1);
    @(posedge clk); #1;
    drive(4'd4, 8'h00, 1'b0, 10'h000);
    @(negedge clk);
    check("post_rst_port_valid", 32'(bus.port_valid), 32'h010);
    check("post_rst_port4_out", 32'(bus.port4_out), 32'h77);
    check("post_rst_drop_count", 32'(bus.drop_count), 32'h0);
    check("post_rst_sel_err", 32'(bus.sel_err), 32'h0);

    // Illegal select streaming, drop counter saturation
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      drive(4'd12, 8'($urandom), 1'b1, 10'h000);
      @(negedge clk);
      check("illegal_ready", 32'(bus.ready_out), 32'h1);
      check("illegal_port_valid", 32'(bus.port_valid), 32'h010);
      if (c == 0) begin
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        @(negedge clk);
        check("illegal_first_sel_err", 32'(bus.sel_err), 32'h1);
        check("illegal_first_drop_count", 32'(bus.drop_count), 32'h1);
      end
    end
    @(posedge clk); #1;
    drive(4'd0, 8'h00, 1'b0, 10'h000);
    @(negedge clk);
    check("illegal_drop_saturated", 32'(bus.drop_count), 32'hFF);
    check("illegal_sel_err_sticky", 32'(bus.sel_err), 32'h1);
    check("illegal_port4_held", 32'(bus.port4_out), 32'h77);

    // Drain everything still held
    @(posedge clk); #1;
    drive(4'd0, 8'h00, 1'b0, 10'h3FF);
    @(posedge clk); #1;
    @(negedge clk);
    check("final_port_valid", 32'(bus.port_valid), 32'h0);
    for (int i = 0; i < 10; i++) check($sformatf("final_queue_empty_p%0d", i), 32'(exp_q[i].size()), 32'h0);
    check("final_sel_err", 32'(bus.sel_err), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/demux_router.md
Name: demux_router

Overview:
- Distribution-side counterpart of the 10-port selector mux: takes one valid/ready input stream plus a port select, and routes each accepted beat to one of 10 output ports.
- Each output port has a one-entry holding register with its own valid/ready handshake, so one stalled port does not block traffic to the other ports.
- Beats with an out-of-range select are consumed and dropped, and are counted.

Parameters:
- DATA_WIDTH, 8, width of the data word on the input and on every output port.
- SEL_WIDTH, 4, width of the select; legal values 0..9, values 10..2^SEL_WIDTH-1 are illegal.
- NUM_PORTS, 10, number of output ports; fixed at 10 because the output ports are individually named.

Ports:
- clk  in  1  single clock, all state on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- sel  in  SEL_WIDTH  destination port for the current input beat.
- data_in  in  DATA_WIDTH  input data word.
- valid_in  in  1  input beat present.
- ready_out  out  1  input beat accepted this cycle when valid_in && ready_out.
- port0_out .. port9_out  out  DATA_WIDTH each  per-port held data.
- port_valid  out  NUM_PORTS  bit i = port i holds a beat.
- port_ready  in  NUM_PORTS  bit i = consumer of port i takes the beat this cycle.
- drop_count  out  8  saturating count of beats dropped for an illegal sel.
- sel_err  out  1  sticky flag, set on the first illegal-sel drop.

Behaviour:
- Reset (async, rst=1): all port_valid bits = 0, all portN_out = 0, drop_count = 0, sel_err = 0. Registers hold these values while rst is high.
- Drain: drain_i = port_valid[i] && port_ready[i]; the beat on port i leaves at that clock edge.
- ready_out is combinational from sel, port_valid and port_ready:
  - sel legal (< 10): ready_out = !port_valid[sel] || port_ready[sel].
  - sel illegal: ready_out = 1.
  - ready_out does not depend on valid_in.
- Accept: accept = valid_in && ready_out.
  - Legal sel: at the edge, port sel data <= data_in and port_valid[sel] <= 1.
  - Latency: data is visible on portN_out with port_valid set in the cycle after acceptance.
- Simultaneous drain and fill of the same port in one cycle:
  - The old beat is consumed and the new beat is loaded.
  - port_valid stays 1, giving full throughput of 1 beat/cycle per port.
- Drain with no fill on port i: port_valid[i] <= 0; portN_out keeps its last value (don't-care while invalid).
- Ports are independent. A fill of one port and drains of any number of other ports can all happen in the same cycle.
- Illegal sel with valid_in:
  - The beat is accepted and discarded; no port changes.
  - drop_count increments by 1 and saturates at 255, with no wrap.
  - sel_err is set and stays set until reset.
- Stability rule (upstream): while valid_in && !ready_out, the upstream holds data_in and sel stable. The block does not need to tolerate a change, but must not corrupt other ports if one occurs.
- Output stability: while port_valid[i] && !port_ready[i], portN_out and port_valid[i] must hold constant.
- Reset mid-operation: all held beats are discarded immediately (valids drop asynchronously). The first accept after rst deasserts behaves as from a clean state.
- No combinational path from data_in to any portN_out; the output data path is fully registered.

Test Plan:
- Reset then idle:
  - rst=1 with random inputs -> port_valid=0, all portN_out=0, drop_count=0, sel_err=0.
  - Release -> ready_out=1 for every legal sel.
- Single route:
  - sel=3, data_in=0xA5, valid_in=1 for one cycle, port_ready=0 -> next cycle port_valid=10'b0000001000, port3_out=0xA5.
  - Then sel=3 again -> ready_out=0.
- Back-to-back, same port:
  - port_ready[7]=1 held; stream 0x01,0x02,0x03 to sel=7 on consecutive cycles -> ready_out stays 1.
  - port7_out shows 0x01,0x02,0x03 on the following consecutive cycles; port_valid[7] stays 1 across them.
- Stall isolation:
  - port2 full with port_ready[2]=0; send sel=5, data 0x3C -> accepted, port5_out=0x3C next cycle.
  - Send sel=2 -> ready_out=0 until port_ready[2]=1, then accepted the same cycle.
- Illegal select:
  - sel=12, valid_in=1 for 300 cycles -> ready_out=1 throughout, no port_valid change.
  - sel_err=1 after the first cycle; drop_count=255, saturated.
- Reset mid-operation:
  - Ports 0, 4 and 9 holding beats; assert rst asynchronously mid-cycle -> port_valid=0 immediately.
  - After release, sel=4 with 0x77 -> port4_out=0x77 one cycle later.
